// File: rtl/paddle_input_ctrl_if.sv
// Paddle controller bus: player inputs from hps_io toward the core, and paddle positions back.
// Level signals only, no valid/ready; the controller samples them on every rising clk_sys edge.
interface paddle_input_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int POS_W  = 8
);
  logic                    freeze;
  logic [NUM_CH-1:0]       joy_up;
  logic [NUM_CH-1:0]       joy_down;
  logic [NUM_CH*8-1:0]     analog_y;
  logic [NUM_CH*POS_W-1:0] paddle_vpos;
  logic [NUM_CH-1:0]       mode_dig;

  modport master (
    output freeze, joy_up, joy_down, analog_y,
    input  paddle_vpos, mode_dig
  );

  modport slave (
    input  freeze, joy_up, joy_down, analog_y,
    output paddle_vpos, mode_dig
  );
endinterface

// File: rtl/paddle_input_ctrl.sv
// Per-channel paddle position generator: analog stick or rate-limited digital up/down.
// Optional macro PADDLE_ACCEL_EN doubles the digital step after ACCEL_TICKS ticks of continuous hold.
module paddle_input_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int POS_W       = 8,
  parameter int TICK_DIV    = 7159,
  parameter int STEP        = 2,
  parameter int DEADZONE    = 16,
  parameter int ACCEL_TICKS = 64
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  paddle_input_ctrl_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [POS_W-1:0] CENTER  = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};
  localparam logic [POS_W:0]   STEP1   = (POS_W+1)'(STEP) << (POS_W-8);
`ifdef PADDLE_ACCEL_EN
  localparam logic [POS_W:0]   STEP2   = STEP1 << 1;
  localparam int HW = $clog2(ACCEL_TICKS+1);
`endif

  typedef enum logic {ANALOG = 1'b0, DIGITAL = 1'b1} mode_t;

  logic [CW-1:0]    presc;
  logic             tick;
  mode_t            mode_q [NUM_CH];
  logic [POS_W-1:0] pos_q  [NUM_CH];

  assign tick = (presc == CW'(TICK_DIV-1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      presc <= '0;
    else if (!bus.freeze)
      presc <= tick ? '0 : presc + CW'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             up, dn, one, over_dz;
    logic [7:0]       raw, mag, u;
    logic [POS_W-1:0] a_pos, pos_d;
    logic [POS_W:0]   step, wide;
    mode_t            mode_d;

    assign up      = bus.joy_up[i];
    assign dn      = bus.joy_down[i];
    assign one     = up ^ dn;
    assign raw     = bus.analog_y[8*i +: 8];
    assign u       = raw + 8'h80;
    assign a_pos   = POS_W'(u) << (POS_W-8);
    // -128 maps to 8'h80, which as unsigned is the correct magnitude 128
    assign mag     = raw[7] ? 8'(~raw + 8'd1) : raw;
    assign over_dz = ({1'b0, mag} > 9'(DEADZONE));

`ifdef PADDLE_ACCEL_EN
    logic [HW-1:0] hold_q, hold_d;
    logic          last_up_q, same_dir;

    assign same_dir = (up == last_up_q);
    assign step     = (hold_q == HW'(ACCEL_TICKS) && same_dir) ? STEP2 : STEP1;

    always_comb begin
      hold_d = hold_q;
      if (mode_d != DIGITAL || !one || !same_dir)
        hold_d = '0;
      else if (tick && mode_q[i] == DIGITAL && hold_q != HW'(ACCEL_TICKS))
        hold_d = hold_q + HW'(1);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        hold_q    <= '0;
        last_up_q <= 1'b0;
      end else if (!bus.freeze) begin
        hold_q    <= hold_d;
        last_up_q <= up;
      end
    end
`else
    assign step = STEP1;
`endif

    // A held direction always wins over the deadzone exit
    always_comb begin
      mode_d = mode_q[i];
      pos_d  = pos_q[i];
      wide   = '0;
      if (one)
        mode_d = DIGITAL;
      else if (mode_q[i] == DIGITAL && over_dz)
        mode_d = ANALOG;

      if (mode_d == ANALOG) begin
        pos_d = a_pos;
      end else if (mode_q[i] == DIGITAL && tick && one) begin
        // Extra MSB catches borrow on up and carry on down
        if (up) begin
          wide  = {1'b0, pos_q[i]} - step;
          pos_d = wide[POS_W] ? '0 : wide[POS_W-1:0];
        end else begin
          wide  = {1'b0, pos_q[i]} + step;
          pos_d = wide[POS_W] ? POS_MAX : wide[POS_W-1:0];
        end
      end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        mode_q[i] <= ANALOG;
        pos_q[i]  <= CENTER;
      end else if (!bus.freeze) begin
        mode_q[i] <= mode_d;
        pos_q[i]  <= pos_d;
      end
    end
  end

  always_comb begin
    bus.paddle_vpos = '0;
    bus.mode_dig    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.paddle_vpos[c*POS_W +: POS_W] = pos_q[c];
      bus.mode_dig[c]                   = (mode_q[c] == DIGITAL);
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Bench for paddle_input_ctrl: directed vector table, hand sequences and random stimulus
// against a cycle-level behavioural model. Build with PADDLE_ACCEL_EN to exercise acceleration.
module tb_paddle_input_ctrl;
  localparam int NUM_CH      = 2;
  localparam int POS_W       = 8;
  localparam int TICK_DIV    = 4;
  localparam int STEP        = 2;
  localparam int DEADZONE    = 16;
  localparam int ACCEL_TICKS = 4;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  paddle_input_ctrl_if #(.NUM_CH(NUM_CH), .POS_W(POS_W)) bus ();

  paddle_input_ctrl #(
    .NUM_CH(NUM_CH), .POS_W(POS_W), .TICK_DIV(TICK_DIV), .STEP(STEP),
    .DEADZONE(DEADZONE), .ACCEL_TICKS(ACCEL_TICKS)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural reference model ----------------
  int m_cnt;
  int m_pos     [NUM_CH];
  bit m_dig     [NUM_CH];
  int m_hold    [NUM_CH];
  bit m_last_up [NUM_CH];

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c]     = 2 ** (POS_W-1);
      m_dig[c]     = 1'b0;
      m_hold[c]    = 0;
      m_last_up[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tick, up, dn, one, nm;
    int a, mag, u, stp;
    if (bus.freeze) return;
    tick  = (m_cnt == TICK_DIV-1);
    m_cnt = tick ? 0 : m_cnt + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      up  = bus.joy_up[c];
      dn  = bus.joy_down[c];
      one = up ^ dn;
      a   = int'($signed(bus.analog_y[8*c +: 8]));
      mag = (a < 0) ? -a : a;
      u   = (a + 384) % 256;
      nm  = one ? 1'b1 : ((m_dig[c] && mag > DEADZONE) ? 1'b0 : m_dig[c]);
      stp = STEP * (2 ** (POS_W-8));
`ifdef PADDLE_ACCEL_EN
      if (m_hold[c] == ACCEL_TICKS && m_last_up[c] == up) stp = 2 * stp;
`endif
      if (!nm)
        m_pos[c] = u * (2 ** (POS_W-8));
      else if (m_dig[c] && tick && one) begin
        if (up) m_pos[c] = (m_pos[c] - stp < 0) ? 0 : m_pos[c] - stp;
        else    m_pos[c] = (m_pos[c] + stp > 2**POS_W - 1) ? 2**POS_W - 1 : m_pos[c] + stp;
      end
`ifdef PADDLE_ACCEL_EN
      if (!nm || !one || m_last_up[c] != up) m_hold[c] = 0;
      else if (tick && m_dig[c] && m_hold[c] < ACCEL_TICKS) m_hold[c]++;
      m_last_up[c] = up;
`endif
      m_dig[c] = nm;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    logic [NUM_CH*POS_W-1:0] ev;
    logic [NUM_CH-1:0]       em;
    for (int c = 0; c < NUM_CH; c++) begin
      ev[c*POS_W +: POS_W] = m_pos[c][POS_W-1:0];
      em[c]                = m_dig[c];
    end
    chk({name, "_vpos"}, 32'(bus.paddle_vpos), 32'(ev));
    chk({name, "_mode"}, 32'(bus.mode_dig), 32'(em));
  endtask

  // One clock: inputs already driven while clk is low, outputs sampled on the falling edge
  task automatic cyc(input string name);
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    chk_model(name);
  endtask

  task automatic set_in(input logic [1:0] up, input logic [1:0] dn, input logic [15:0] ay);
    bus.joy_up   = up;
    bus.joy_down = dn;
    bus.analog_y = ay;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n    = 1'b0;
    bus.freeze = 1'b0;
    set_in(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
    model_reset();
    @(negedge clk_sys);
    chk("reset_vpos", 32'(bus.paddle_vpos), 32'h8080);
    chk("reset_mode", 32'(bus.mode_dig), 32'h0);
    set_in(2'b00, 2'b00, 16'h0000);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  up;
    logic [1:0]  dn;
    logic [15:0] ay;
    logic [15:0] exp_vpos;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [1:0] up_r, dn_r;
    logic [15:0] ay_r;

    // {up, down, analog_y{ch1,ch0}, expected vpos{ch1,ch0}, expected mode_dig}
    vecs[0]  = '{2'b00, 2'b00, 16'h8040, 16'h00C0, 2'b00};
    vecs[1]  = '{2'b01, 2'b00, 16'h807F, 16'h00C0, 2'b01};
    vecs[2]  = '{2'b00, 2'b00, 16'h807F, 16'h00FF, 2'b00};
    vecs[3]  = '{2'b01, 2'b00, 16'h807F, 16'h00FF, 2'b01};
    vecs[4]  = '{2'b00, 2'b00, 16'h8010, 16'h00FF, 2'b01};
    vecs[5]  = '{2'b00, 2'b00, 16'h7F10, 16'hFFFF, 2'b01};
    vecs[6]  = '{2'b00, 2'b00, 16'h7FF0, 16'hFFFF, 2'b01};
    vecs[7]  = '{2'b00, 2'b00, 16'h7FEF, 16'hFF6F, 2'b00};
    vecs[8]  = '{2'b00, 2'b00, 16'h0080, 16'h8000, 2'b00};
    vecs[9]  = '{2'b00, 2'b10, 16'h0080, 16'h8000, 2'b10};
    vecs[10] = '{2'b00, 2'b10, 16'h0080, 16'h8000, 2'b10};
    vecs[11] = '{2'b00, 2'b10, 16'h0080, 16'h8200, 2'b10};
    vecs[12] = '{2'b10, 2'b10, 16'h0080, 16'h8200, 2'b10};

    bus.freeze = 1'b0;
    set_in(2'b00, 2'b00, 16'h0000);

    // Directed table: analog mapping, mode arbitration, deadzone edge, first digital tick
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].up, vecs[i].dn, vecs[i].ay);
      cyc($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_vpos", i), 32'(bus.paddle_vpos), 32'(vecs[i].exp_vpos));
      chk($sformatf("vec%0d_mode", i), 32'(bus.mode_dig), 32'(vecs[i].exp_mode));
    end

    // Digital ramp from center with ch0 down held
    do_reset();
    set_in(2'b00, 2'b01, 16'h0000);
    repeat (4) cyc("ramp");
    chk("ramp_t1", 32'(bus.paddle_vpos[7:0]), 32'h82);
    repeat (4) cyc("ramp");
    chk("ramp_t2", 32'(bus.paddle_vpos[7:0]), 32'h84);
`ifdef PADDLE_ACCEL_EN
    repeat (4) cyc("accel");
    chk("accel_t3", 32'(bus.paddle_vpos[7:0]), 32'h86);
    repeat (4) cyc("accel");
    chk("accel_t4", 32'(bus.paddle_vpos[7:0]), 32'h88);
    repeat (4) cyc("accel");
    chk("accel_t5", 32'(bus.paddle_vpos[7:0]), 32'h8C);
    repeat (4) cyc("accel");
    chk("accel_t6", 32'(bus.paddle_vpos[7:0]), 32'h90);
    set_in(2'b01, 2'b00, 16'h0000);
    repeat (4) cyc("accel_rev");
    chk("accel_rev1", 32'(bus.paddle_vpos[7:0]), 32'h8E);
    repeat (4) cyc("accel_rev");
    chk("accel_rev2", 32'(bus.paddle_vpos[7:0]), 32'h8C);
`else
    repeat (4 * 70) cyc("ramp");
    chk("ramp_sat", 32'(bus.paddle_vpos[7:0]), 32'hFF);
    repeat (8) cyc("ramp");
    chk("ramp_hold", 32'(bus.paddle_vpos[7:0]), 32'hFF);
`endif

    // Asynchronous reset in the middle of a ramp
    do_reset();
    set_in(2'b00, 2'b01, 16'h0000);
    repeat (10) cyc("mid");
    reset_n = 1'b0;
    #1;
    chk("midreset_vpos", 32'(bus.paddle_vpos), 32'h8080);
    chk("midreset_mode", 32'(bus.mode_dig), 32'h0);
    model_reset();
    set_in(2'b00, 2'b00, 16'h0000);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Up toward the top edge from 8'h01: floors at zero
    do_reset();
    set_in(2'b00, 2'b00, 16'h0081);
    cyc("floor");
    chk("floor_start", 32'(bus.paddle_vpos[7:0]), 32'h01);
    set_in(2'b01, 2'b00, 16'h0081);
    repeat (12) cyc("floor");
    chk("floor_zero", 32'(bus.paddle_vpos[7:0]), 32'h00);
    repeat (8) cyc("floor");
    chk("floor_hold", 32'(bus.paddle_vpos[7:0]), 32'h00);

    // Freeze across three tick boundaries, then resume on the next tick
    do_reset();
    set_in(2'b00, 2'b01, 16'h0000);
    repeat (8) cyc("frz");
    bus.freeze = 1'b1;
    repeat (14) cyc("frz");
    chk("freeze_hold", 32'(bus.paddle_vpos[7:0]), 32'h84);
    bus.freeze = 1'b0;
    repeat (3) cyc("frz");
    chk("freeze_pre", 32'(bus.paddle_vpos[7:0]), 32'h84);
    cyc("frz");
    chk("freeze_resume", 32'(bus.paddle_vpos[7:0]), 32'h86);

    // Randomized traffic against the model
    do_reset();
    up_r = 2'b00; dn_r = 2'b00; ay_r = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      bus.freeze = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) up_r[c] = 1'($urandom);
        if ($urandom_range(0, 7) == 0) dn_r[c] = 1'($urandom);
        if ($urandom_range(0, 3) == 0)
          ay_r[8*c +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                                       : 8'($urandom_range(0, 36) - 18);
      end
      set_in(up_r, dn_r, ay_r);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
